uart_tx: RTL and testbench

//  Synthesizable UART transmitter, 8N1, LSB first, driving a serial tx line at

---
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, one bit per DIV clocks, valid/ready byte input.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned DIV        = 10,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       uart_clk,
  input  logic       uart_rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx_data,
  output logic       busy
);

  localparam int unsigned DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] STOP_LAST = DW'(DIV - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            wrap;

`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`else
  logic            unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign wrap = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = wrap ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        tx_d  = 1'b1;
        if (in_valid && ready_q) begin
          shift_d = in_data;
`ifdef UART_TX_PARITY_EN
          par_d   = (^in_data) ^ PARITY_ODD;
`endif
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        // STOP holds DIV-1 cycles; the stop bit's final cycle is spent in IDLE
        // so a new byte can be accepted there and frames pack at exactly 10*DIV.
        if (div_q == STOP_LAST) begin
          state_d = S_IDLE;
          div_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign in_ready = ready_q;
  assign tx_data  = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two instances (DIV=10 and DIV=2) sharing stimulus via sel.
// Honours UART_TX_PARITY_EN for frame length and parity expectations.
module tb_uart_tx;
  localparam int unsigned DIV_A = 10;
  localparam int unsigned DIV_B = 2;
  localparam bit          ODD   = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] in_data = '0;
  logic       va, vb;
  logic       ready_a, tx_a, busy_a;
  logic       ready_b, tx_b, busy_b;
  logic       rdy, txd, bsy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  assign va  = in_valid & ~sel;
  assign vb  = in_valid & sel;
  assign rdy = sel ? ready_b : ready_a;
  assign txd = sel ? tx_b : tx_a;
  assign bsy = sel ? busy_b : busy_a;

  uart_tx #(.DIV(DIV_A), .PARITY_ODD(ODD)) dut_a (
    .uart_clk(clk), .uart_rst(rst), .in_valid(va), .in_data(in_data),
    .in_ready(ready_a), .tx_data(tx_a), .busy(busy_a)
  );

  uart_tx #(.DIV(DIV_B), .PARITY_ODD(ODD)) dut_b (
    .uart_clk(clk), .uart_rst(rst), .in_valid(vb), .in_data(in_data),
    .in_ready(ready_b), .tx_data(tx_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  function automatic logic exp_tx(input logic [7:0] b, input int unsigned k, input int unsigned d);
    int unsigned idx;
    idx = (k - 1) / d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return (^b) ^ ODD;
`endif
    return 1'b1;
  endfunction

  // Called at a negedge; the accept happens on the following posedge (cycle T).
  task automatic frame(input logic [7:0] b, input bit hold, input logic [7:0] nxt,
                       input int unsigned pulse_k, input string tag);
    int unsigned d;
    logic e, idle;
    d = sel ? DIV_B : DIV_A;
    in_valid = 1'b1;
    in_data  = b;
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s accept_ready: got %b want 1", tag, rdy);
    end
    @(posedge clk);
    for (int unsigned k = 1; k <= NBITS * d; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) in_data = nxt;
        else begin
          in_valid = 1'b0;
          in_data  = ~b;
        end
      end
      if (pulse_k != 0 && k == pulse_k) begin
        in_valid = 1'b1;
        in_data  = 8'hFF;
      end
      if (pulse_k != 0 && k == pulse_k + 1) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      e = exp_tx(b, k, d);
      vectors++;
      if (txd !== e) begin
        miscompares++;
        $display("FAIL %s tx cycle T+%0d: got %b want %b", tag, k, txd, e);
      end
      idle = (k == NBITS * d);
      vectors++;
      if ({rdy, bsy} !== {idle, ~idle}) begin
        miscompares++;
        $display("FAIL %s ready/busy cycle T+%0d: got %b%b want %b%b", tag, k, rdy, bsy, idle, ~idle);
      end
    end
  endtask

  task automatic check_idle(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      vectors++;
      if ({txd, rdy, bsy} !== 3'b110) begin
        miscompares++;
        $display("FAIL %s idle: got tx/ready/busy=%b%b%b want 110", tag, txd, rdy, bsy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    @(posedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({tx_a, ready_a, busy_a, tx_b, ready_b, busy_b} !== 6'b110110) begin
        miscompares++;
        $display("FAIL reset_state: got %b%b%b %b%b%b want 110 110",
                 tx_a, ready_a, busy_a, tx_b, ready_b, busy_b);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    check_idle(3, "post_reset");
  endtask

  task automatic test_single();
    sel = 1'b0;
    frame(8'h41, 1'b0, 8'h00, 0, "single_41");
    check_idle(5, "single_41_after");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    frame(8'h48, 1'b1, 8'h69, 0, "b2b_H");
    frame(8'h69, 1'b1, 8'h0A, 0, "b2b_i");
    frame(8'h0A, 1'b0, 8'h00, 0, "b2b_nl");
    check_idle(5, "b2b_after");
  endtask

  task automatic test_ignore_busy();
    sel = 1'b0;
    frame(8'h3C, 1'b0, 8'h00, 35, "ignore_ff");
    check_idle(2 * DIV_A, "ignore_no_extra");
  endtask

  task automatic test_reset_midframe();
    logic e;
    sel = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk);
    for (int unsigned k = 1; k <= 6 * DIV_A; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      e = exp_tx(8'h55, k, DIV_A);
      vectors++;
      if (txd !== e) begin
        miscompares++;
        $display("FAIL rst_mid tx cycle T+%0d: got %b want %b", k, txd, e);
      end
    end
    // Next cycle would carry data bit 5 (0) without the reset.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({txd, rdy, bsy} !== 3'b110) begin
        miscompares++;
        $display("FAIL rst_mid state: got tx/ready/busy=%b%b%b want 110", txd, rdy, bsy);
      end
    end
    rst = 1'b0;
    frame(8'hA5, 1'b0, 8'h00, 0, "after_rst_A5");
    check_idle(3, "after_rst_idle");
  endtask

  task automatic test_div2();
    sel = 1'b1;
    frame(8'h00, 1'b1, 8'hFF, 0, "div2_00");
    frame(8'hFF, 1'b0, 8'h00, 0, "div2_FF");
    check_idle(4, "div2_after");
    sel = 1'b0;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    sel = 1'b0;
    frame(8'h07, 1'b0, 8'h00, 0, "parity_07");
    check_idle(3, "parity_after");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midframe();
    test_div2();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
